mdu_exec: RTL

- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands, i.e. the outputs of the ALU A/B forwarding muxes.
- Performs the multi-cycle MULT/MULTU/DIV/DIVU operations and the MTHI/MTLO writes.
- Exposes the HI/LO registers and a busy flag; the hazard unit uses the busy flag to stall MD-class instructions sitting in D.

---
 rtl/mdu_exec.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mdu_exec.sv
// Execute-stage multiply/divide unit with HI/LO registers and busy/stall flags.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_exec #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam logic [4:0] MUL_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi_d, res_lo_d;
    logic        is_mul, is_div;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    logic signed [63:0] sa, sb, prod_s;
    logic [63:0]        prod_u;

    assign sa     = {{32{a_q[31]}}, a_q};
    assign sb     = {{32{b_q[31]}}, b_q};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divide on magnitudes, then fix signs; this also makes
    // 0x80000000 / -1 wrap to 0x80000000 with no special case.
    logic        sgn, neg_a, neg_b, b_zero;
    logic [31:0] ua, ub, uq, ur, quo, rem;

    assign sgn    = (op_q == OP_DIV);
    assign neg_a  = sgn & a_q[31];
    assign neg_b  = sgn & b_q[31];
    assign ua     = neg_a ? (32'd0 - a_q) : a_q;
    assign ub     = neg_b ? (32'd0 - b_q) : b_q;
    assign b_zero = (b_q == 32'd0);
    assign uq     = b_zero ? 32'd0 : ua / ub;
    assign ur     = b_zero ? 32'd0 : ua % ub;
    assign quo    = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem    = neg_a ? (32'd0 - ur) : ur;

    always_comb begin
        res_hi_d = hi_q;
        res_lo_d = lo_q;
        case (op_q)
            OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
            OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (!b_zero) begin
                    res_lo_d = quo;
                    res_hi_d = rem;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_q <= 1'b0;
                hi_q   <= res_hi_d;
                lo_q   <= res_lo_d;
            end
        end else if (start) begin
            if (is_mul || is_div) begin
                busy_q <= 1'b1;
                op_q   <= op;
                a_q    <= src_a;
                b_q    <= src_b;
                cnt_q  <= is_mul ? MUL_N : DIV_N;
            end else if (op == OP_MTHI) begin
                hi_q <= src_a;
            end else if (op == OP_MTLO) begin
                lo_q <= src_a;
            end
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = busy_q | (start & (is_mul | is_div));

endmodule
